div_restoring_param: RTL and testbench

Parametrised successor to the team's 32-bit unsigned early-start restoring divider. It covers all four RISC-V M-extension divide operations (DIV, DIVU, REM, REMU) at any width, producing quotient and remainder together. Sign handling and RISC-V special-case results are built in, and skipping of leading-zero iterations can be enabled or disabled. It sits behind the MULDIV decode stage, which selects q_out or r_out.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_restoring_param_lop.sv | 22 ++
 rtl/div_restoring_param.sv | 182 ++++++++++++++++++
 tb/tb_div_restoring_param.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the parametrised restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    LOOP = 2'd2,
    SIGN = 2'd3
  } div_state_e;

  // Iteration counter must hold values up to WIDTH.
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

  // Bits needed to index any bit of a WIDTH-wide operand.
  function automatic int pos_bits(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_restoring_param_lop.sv
// Leading-one priority encoder: index of the highest set bit plus an all-zero flag.
module lead_one_pos
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PW    = pos_bits(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  output logic [PW-1:0]    pos,
  output logic             zero
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    pos  = {PW{1'b0}};
    zero = ~|value;
    for (int i = 0; i < WIDTH; i++) begin
      pos = value[i] ? PW'(i) : pos;
    end
  end

endmodule

// File: rtl/div_restoring_param.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with optional leading-zero skip.
module div_restoring_param
  import div_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter bit EARLY_START = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             busy,
  output logic             done,
  output logic             dbz_out
);

  localparam int CW = cnt_bits(WIDTH);
  localparam int PW = pos_bits(WIDTH);

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + WIDTH'(1)) : x;
  endfunction

  div_state_e       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sgn_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] bmag_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0]   amag_s;
  logic [WIDTH-1:0]   bmag_s;
  logic [PW-1:0]      pos_a_s;
  logic [PW-1:0]      pos_b_s;
  logic               zero_a_s;
  logic               zero_b_s;
  logic [CW-1:0]      k_s;
  logic [CW-1:0]      shamt_s;
  logic [2*WIDTH-1:0] pair_s;
  logic [WIDTH+1:0]   diff_s;
  logic               borrow_s;
  logic               diff_unused_s;
  logic               neg_q_s;
  logic               neg_r_s;
  logic               min_ovf_s;
  logic               a_lt_b_s;

  // Operand magnitudes and case classification, all from the latched operands.
  always_comb begin
    amag_s    = cond_neg(a_r, sgn_r & a_r[WIDTH-1]);
    bmag_s    = cond_neg(b_r, sgn_r & b_r[WIDTH-1]);
    neg_q_s   = sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
    neg_r_s   = sgn_r & a_r[WIDTH-1];
    min_ovf_s = sgn_r && (a_r == {1'b1, {(WIDTH-1){1'b0}}}) && (b_r == {WIDTH{1'b1}});
    a_lt_b_s  = zero_a_s || (amag_s < bmag_s);
  end

  lead_one_pos #(.WIDTH(WIDTH), .PW(PW)) u_lop_a (
    .value (amag_s),
    .pos   (pos_a_s),
    .zero  (zero_a_s)
  );

  lead_one_pos #(.WIDTH(WIDTH), .PW(PW)) u_lop_b (
    .value (bmag_s),
    .pos   (pos_b_s),
    .zero  (zero_b_s)
  );

  // Iteration count and the pre-shifted {r,q} pair; high dividend bits land in r already reduced.
  always_comb begin
    if (EARLY_START) begin
      k_s = CW'(pos_a_s) - CW'(pos_b_s) + CW'(1);
    end else begin
      k_s = CW'(WIDTH);
    end
    shamt_s = CW'(WIDTH) - k_s;
    pair_s  = {{WIDTH{1'b0}}, amag_s} << shamt_s;
  end

  // Trial subtraction, widened by one extra bit so the top bit is the borrow.
  always_comb begin
    diff_s        = {1'b0, rem_r, quo_r[WIDTH-1]} - {2'b00, bmag_r};
    borrow_s      = diff_s[WIDTH+1];
    diff_unused_s = diff_s[WIDTH];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sgn_r   <= 1'b0;
      rem_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      bmag_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      q_out   <= {WIDTH{1'b0}};
      r_out   <= {WIDTH{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_in) begin
            a_r     <= a_in;
            b_r     <= b_in;
            sgn_r   <= signed_in;
            busy    <= 1'b1;
            state_r <= PREP;
          end
        end
        PREP: begin
          if (zero_b_s) begin
            q_out   <= {WIDTH{1'b1}};
            r_out   <= a_r;
            dbz_out <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (min_ovf_s) begin
            q_out   <= a_r;
            r_out   <= {WIDTH{1'b0}};
            dbz_out <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (a_lt_b_s) begin
            q_out   <= {WIDTH{1'b0}};
            r_out   <= a_r;
            dbz_out <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            rem_r   <= pair_s[2*WIDTH-1:WIDTH];
            quo_r   <= pair_s[WIDTH-1:0];
            bmag_r  <= bmag_s;
            cnt_r   <= k_s - CW'(1);
            state_r <= LOOP;
          end
        end
        LOOP: begin
          if (borrow_s) begin
            rem_r <= {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
            quo_r <= {quo_r[WIDTH-2:0], 1'b0};
          end else begin
            rem_r <= diff_s[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], 1'b1};
          end
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= SIGN;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        SIGN: begin
          q_out   <= cond_neg(quo_r, neg_q_s);
          r_out   <= cond_neg(rem_r, neg_r_s);
          dbz_out <= 1'b0;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_restoring_param.sv
// Directed and model-checked bench for div_restoring_param at WIDTH 32 (both skip modes) and 8.
module tb_div_restoring_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start_v;
  logic [2:0]  sg_v;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];

  logic [31:0] q0, r0, q1, r1;
  logic [7:0]  q2, r2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic        dbz0, dbz1, dbz2;

  int total = 0;
  int bad   = 0;
  int dcnt0 = 0;

  always #5 clk = ~clk;

  div_restoring_param #(.WIDTH(32), .EARLY_START(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .start_in(start_v[0]), .signed_in(sg_v[0]),
    .a_in(a_v[0]), .b_in(b_v[0]), .q_out(q0), .r_out(r0),
    .busy(busy0), .done(done0), .dbz_out(dbz0));

  div_restoring_param #(.WIDTH(32), .EARLY_START(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .start_in(start_v[1]), .signed_in(sg_v[1]),
    .a_in(a_v[1]), .b_in(b_v[1]), .q_out(q1), .r_out(r1),
    .busy(busy1), .done(done1), .dbz_out(dbz1));

  div_restoring_param #(.WIDTH(8), .EARLY_START(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .start_in(start_v[2]), .signed_in(sg_v[2]),
    .a_in(a_v[2][7:0]), .b_in(b_v[2][7:0]), .q_out(q2), .r_out(r2),
    .busy(busy2), .done(done2), .dbz_out(dbz2));

  always @(negedge clk) begin
    if (done0) dcnt0 <= dcnt0 + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] q_of(input int sel);
    case (sel)
      0:       return q0;
      1:       return q1;
      default: return {24'h0, q2};
    endcase
  endfunction

  function automatic logic [31:0] r_of(input int sel);
    case (sel)
      0:       return r0;
      1:       return r1;
      default: return {24'h0, r2};
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic dbz_of(input int sel);
    case (sel)
      0:       return dbz0;
      1:       return dbz1;
      default: return dbz2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; returns #1 after the accept edge.
  task automatic issue(input int sel, input logic sg, input logic [31:0] a, input logic [31:0] b);
    start_v[sel] = 1'b1;
    sg_v[sel]    = sg;
    a_v[sel]     = a;
    b_v[sel]     = b;
    @(posedge clk);
    #1;
    start_v[sel] = 1'b0;
  endtask

  // lat counts edges from the accept edge (inclusive) to the edge that raised done.
  task automatic wait_done(input int sel, output int lat);
    lat = 1;
    while (done_of(sel) !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input int sel, input logic sg,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er,
                     input logic edbz, input int elat);
    int lat;
    @(negedge clk);
    issue(sel, sg, a, b);
    wait_done(sel, lat);
    chk({tag, ".done"}, {31'h0, done_of(sel)}, 32'h1);
    chk({tag, ".q"}, q_of(sel), eq);
    chk({tag, ".r"}, r_of(sel), er);
    chk({tag, ".dbz"}, {31'h0, dbz_of(sel)}, {31'h0, edbz});
    if (elat > 0) chk({tag, ".lat"}, 32'(lat), 32'(elat));
  endtask

  // Reference: truncating division on widened integers, RISC-V results for b==0.
  task automatic model(input int w, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    logic [31:0] mask;
    longint sa, sb, lq, lr;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    if (b == 32'h0) begin
      q = mask;
      r = a;
    end else if (sg) begin
      sa = a[w-1] ? (longint'(a) - (64'sd1 <<< w)) : longint'(a);
      sb = b[w-1] ? (longint'(b) - (64'sd1 <<< w)) : longint'(b);
      lq = sa / sb;
      lr = sa % sb;
      q  = 32'(lq) & mask;
      r  = 32'(lr) & mask;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  initial begin
    int lat;
    int n0;
    int sel;
    int w;
    logic sg;
    logic [31:0] a, b, eq, er, mask;

    rst     = 1'b1;
    start_v = 3'b000;
    sg_v    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      a_v[i] = 32'h0;
      b_v[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset.q", q0, 32'h0);
    chk("reset.r", r0, 32'h0);
    chk("reset.busy", {31'h0, busy0}, 32'h0);
    chk("reset.done", {31'h0, done0}, 32'h0);
    chk("reset.dbz", {31'h0, dbz0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run("u100_7",   0, 1'b0, 32'd100,       32'd7,        32'd14,        32'd2,         1'b0, 8);
    run("s-7_2",    0, 1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 5);
    run("s7_-2",    0, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0, 5);
    run("u5_0",     0, 1'b0, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'd5,         1'b1, 2);
    run("sovf",     0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,        1'b0, 2);
    run("u3_10",    0, 1'b0, 32'd3,         32'd10,       32'd0,         32'd3,         1'b0, 2);
    run("umax_1",   0, 1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'h0,         1'b0, 35);
    run("smin_2",   0, 1'b1, 32'h8000_0000, 32'd2,        32'hC000_0000, 32'h0,         1'b0, 34);
    run("s-1_min",  0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,        32'hFFFF_FFFF, 1'b0, 2);
    run("s-5_0",    0, 1'b1, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 2);
    run("noes100_7",1, 1'b0, 32'd100,       32'd7,        32'd14,        32'd2,         1'b0, 35);
    run("noes-100_7",1,1'b1, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 35);
    run("w8smin_3", 2, 1'b1, 32'h80,        32'h03,       32'hD6,        32'hFE,        1'b0, 10);
    run("w8uff_10", 2, 1'b0, 32'hFF,        32'h10,       32'h0F,        32'h0F,        1'b0, 7);
    run("w8sovf",   2, 1'b1, 32'h80,        32'hFF,       32'h80,        32'h00,        1'b0, 2);
    run("w8s7f_80", 2, 1'b1, 32'h7F,        32'h80,       32'h00,        32'h7F,        1'b0, 2);

    // start held high with changing operands after accept: one op, one done pulse.
    @(negedge clk);
    n0 = dcnt0;
    start_v[0] = 1'b1;
    sg_v[0]    = 1'b0;
    a_v[0]     = 32'd100;
    b_v[0]     = 32'd7;
    lat = 0;
    for (int i = 0; i < 60 && done0 !== 1'b1; i++) begin
      @(posedge clk);
      #1;
      lat++;
      a_v[0]  = $urandom;
      b_v[0]  = $urandom;
      sg_v[0] = 1'b1;
    end
    start_v[0] = 1'b0;
    chk("hold.lat", 32'(lat), 32'd8);
    chk("hold.q", q0, 32'd14);
    chk("hold.r", r0, 32'd2);
    repeat (12) @(posedge clk);
    #1;
    chk("hold.pulses", 32'(dcnt0 - n0), 32'd1);
    chk("hold.idle", {31'h0, busy0}, 32'h0);

    // New request on the done cycle is accepted; old results remain until it resolves.
    run("b2b.first", 0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 8);
    issue(0, 1'b0, 32'd3, 32'd10);
    chk("b2b.busy", {31'h0, busy0}, 32'h1);
    chk("b2b.oldq", q0, 32'd14);
    wait_done(0, lat);
    chk("b2b.lat", 32'(lat), 32'd2);
    chk("b2b.q", q0, 32'd0);
    chk("b2b.r", r0, 32'd3);

    // Reset in the middle of a long loop.
    run("prerst", 0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 8);
    @(negedge clk);
    issue(0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    n0  = dcnt0;
    rst = 1'b1;
    #1;
    chk("midrst.q", q0, 32'h0);
    chk("midrst.r", r0, 32'h0);
    chk("midrst.busy", {31'h0, busy0}, 32'h0);
    chk("midrst.done", {31'h0, done0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst.nodone", 32'(dcnt0 - n0), 32'd0);
    chk("midrst.idle", {31'h0, busy0}, 32'h0);

    // Random operands, alternating widths, with forced MIN_INT and small divisors.
    for (int i = 0; i < 32; i++) begin
      sel  = (i % 2 == 1) ? 2 : 0;
      w    = (sel == 2) ? 8 : 32;
      mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      sg   = (i % 3 != 0);
      a    = $urandom & mask;
      b    = ($urandom >> $urandom_range(0, w - 1)) & mask;
      if (i % 4 == 0) a = 32'h1 << (w - 1);
      if (i % 5 == 2) b = mask;
      if (i % 7 == 3) b = 32'(int'($urandom_range(1, 15)));
      model(w, sg, a, b, eq, er);
      run("rand", sel, sg, a, b, eq, er, (b == 32'h0), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
